// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: merges ALU and load results into one regfile commit per cycle
// Buffers colliding loads, forwards the in-flight commit and flags reads of pending loads.
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int RW    = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_alu_valid,
    input  logic [RW-1:0]              i_alu_reg,
    input  logic [W-1:0]               i_alu_val,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [RW-1:0]              i_ld_reg,
    input  logic [W-1:0]               i_ld_val,
    output logic                       o_wb_en,
    output logic [RW-1:0]              o_wb_reg,
    output logic [W-1:0]               o_wb_val,
    input  logic [RW-1:0]              i_rd_reg0,
    input  logic [RW-1:0]              i_rd_reg1,
    output logic                       o_fwd0_hit,
    output logic [W-1:0]               o_fwd0_val,
    output logic                       o_fwd1_hit,
    output logic [W-1:0]               o_fwd1_val,
    output logic                       o_haz0,
    output logic                       o_haz1,
    output logic [$clog2(DEPTH):0]     o_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [RW-1:0]    buf_reg_q [DEPTH];
    logic [RW-1:0]    buf_reg_d [DEPTH];
    logic [W-1:0]     buf_val_q [DEPTH];
    logic [W-1:0]     buf_val_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_en_q, ready_en_d;
    logic             wb_en_q, wb_en_d;
    logic [RW-1:0]    wb_reg_q, wb_reg_d;
    logic [W-1:0]     wb_val_q, wb_val_d;

    logic             ld_acc;
    logic             push, pop;
    logic             sel_valid;
    logic [RW-1:0]    sel_reg;
    logic [W-1:0]     sel_val;
    logic [DEPTH-1:0] match0, match1;

    // ready_en_q keeps the load port closed while reset is asserted
    assign o_ld_ready = ready_en_q && (count_q < CW'(DEPTH));
    assign ld_acc     = i_ld_valid && o_ld_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_reg_d[i] = buf_reg_q[i];
            buf_val_d[i] = buf_val_q[i];
        end
        live_d     = live_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ready_en_d = 1'b1;
        wb_en_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_val_d   = wb_val_q;
        sel_valid  = 1'b0;
        sel_reg    = '0;
        sel_val    = '0;
        pop        = 1'b0;
        push       = ld_acc;

        if (i_alu_valid) begin
            sel_valid = 1'b1;
            sel_reg   = i_alu_reg;
            sel_val   = i_alu_val;
            // the ALU result is younger than every buffered load to the same register
            for (int i = 0; i < DEPTH; i++) begin
                if (buf_reg_q[i] == i_alu_reg) begin
                    live_d[i] = 1'b0;
                end
            end
        end else if (count_q != '0) begin
            pop       = 1'b1;
            sel_valid = live_q[rd_ptr_q];
            sel_reg   = buf_reg_q[rd_ptr_q];
            sel_val   = buf_val_q[rd_ptr_q];
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d  = rd_ptr_q + PW'(1);
        end else if (ld_acc) begin
            sel_valid = 1'b1;
            sel_reg   = i_ld_reg;
            sel_val   = i_ld_val;
            push      = 1'b0;
        end

        // pushed after the kill so a same-cycle load is never killed
        if (push) begin
            buf_reg_d[wr_ptr_q] = i_ld_reg;
            buf_val_d[wr_ptr_q] = i_ld_val;
            live_d[wr_ptr_q]    = 1'b1;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (sel_valid && (sel_reg != '0)) begin
            wb_en_d  = 1'b1;
            wb_reg_d = sel_reg;
            wb_val_d = sel_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg_q[i] <= '0;
                buf_val_q[i] <= '0;
            end
            live_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_val_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg_q[i] <= buf_reg_d[i];
                buf_val_q[i] <= buf_val_d[i];
            end
            live_q     <= live_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_val_q   <= wb_val_d;
        end
    end

    always_comb begin
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match0[i] = live_q[i] && (buf_reg_q[i] == i_rd_reg0);
            match1[i] = live_q[i] && (buf_reg_q[i] == i_rd_reg1);
        end
    end

    assign o_wb_en    = wb_en_q;
    assign o_wb_reg   = wb_reg_q;
    assign o_wb_val   = wb_val_q;
    assign o_pending  = count_q;
    assign o_fwd0_hit = wb_en_q && (wb_reg_q == i_rd_reg0) && (i_rd_reg0 != '0);
    assign o_fwd1_hit = wb_en_q && (wb_reg_q == i_rd_reg1) && (i_rd_reg1 != '0);
    assign o_fwd0_val = wb_val_q;
    assign o_fwd1_val = wb_val_q;
    assign o_haz0     = (|match0) && (i_rd_reg0 != '0);
    assign o_haz1     = (|match1) && (i_rd_reg1 != '0);

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_val;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_val;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic [4:0]  rd_reg0;
    logic [4:0]  rd_reg1;
    logic        fwd0_hit;
    logic [31:0] fwd0_val;
    logic        fwd1_hit;
    logic [31:0] fwd1_val;
    logic        haz0;
    logic        haz1;
    logic [1:0]  pending;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage #(.DEPTH(2), .W(32), .RW(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_alu_valid (alu_valid),
        .i_alu_reg   (alu_reg),
        .i_alu_val   (alu_val),
        .i_ld_valid  (ld_valid),
        .o_ld_ready  (ld_ready),
        .i_ld_reg    (ld_reg),
        .i_ld_val    (ld_val),
        .o_wb_en     (wb_en),
        .o_wb_reg    (wb_reg),
        .o_wb_val    (wb_val),
        .i_rd_reg0   (rd_reg0),
        .i_rd_reg1   (rd_reg1),
        .o_fwd0_hit  (fwd0_hit),
        .o_fwd0_val  (fwd0_val),
        .o_fwd1_hit  (fwd1_hit),
        .o_fwd1_val  (fwd1_val),
        .o_haz0      (haz0),
        .o_haz1      (haz1),
        .o_pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_val   = '0;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_val    = '0;
    endtask

    task automatic set_alu(input logic [4:0] r, input logic [31:0] v);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_val   = v;
    endtask

    task automatic set_ld(input logic [4:0] r, input logic [31:0] v);
        ld_valid = 1'b1;
        ld_reg   = r;
        ld_val   = v;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] r,
                            input logic [31:0] v, input logic [1:0] pend);
        check({tag, ".en"},   32'(wb_en),   32'(en));
        check({tag, ".reg"},  32'(wb_reg),  32'(r));
        check({tag, ".val"},  wb_val,       v);
        check({tag, ".pend"}, 32'(pending), 32'(pend));
    endtask

    initial begin
        idle_inputs();
        rd_reg0 = '0;
        rd_reg1 = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_wb("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        check("reset.ready", 32'(ld_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset.ready", 32'(ld_ready), 32'd1);
        check("post_reset.en", 32'(wb_en), 32'd0);

        // lone load, buffer empty: latency 1, then held
        set_ld(5'd5, 32'hAA);
        tick();
        idle_inputs();
        check_wb("ld_r5", 1'b1, 5'd5, 32'hAA, 2'd0);
        tick();
        check_wb("ld_r5_hold", 1'b0, 5'd5, 32'hAA, 2'd0);

        // ALU and load together
        set_alu(5'd3, 32'h11);
        set_ld(5'd4, 32'h22);
        tick();
        idle_inputs();
        check_wb("alu_r3", 1'b1, 5'd3, 32'h11, 2'd1);
        rd_reg0 = 5'd4;
        #1;
        check("haz_r4", 32'(haz0), 32'd1);
        tick();
        check_wb("ld_r4", 1'b1, 5'd4, 32'h22, 2'd0);
        check("haz_r4_gone", 32'(haz0), 32'd0);
        rd_reg0 = '0;

        // fill the buffer during an ALU streak
        set_alu(5'd1, 32'h1);
        set_ld(5'd10, 32'hA0);
        tick();
        check("fill1.pend", 32'(pending), 32'd1);
        check("fill1.ready", 32'(ld_ready), 32'd1);
        set_alu(5'd2, 32'h2);
        set_ld(5'd11, 32'hB0);
        tick();
        check_wb("fill2", 1'b1, 5'd2, 32'h2, 2'd2);
        check("fill2.ready", 32'(ld_ready), 32'd0);
        set_alu(5'd1, 32'h3);
        set_ld(5'd12, 32'hC0);
        tick();
        check_wb("full_alu", 1'b1, 5'd1, 32'h3, 2'd2);
        check("full.ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        tick();
        check_wb("pop_r10", 1'b1, 5'd10, 32'hA0, 2'd1);
        check("recover.ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        check_wb("pop_r11", 1'b1, 5'd11, 32'hB0, 2'd1);
        tick();
        check_wb("pop_r12", 1'b1, 5'd12, 32'hC0, 2'd0);

        // buffered r7 killed by a younger ALU write
        set_alu(5'd6, 32'h66);
        set_ld(5'd7, 32'h77);
        tick();
        idle_inputs();
        rd_reg1 = 5'd7;
        #1;
        check_wb("alu_r6", 1'b1, 5'd6, 32'h66, 2'd1);
        check("haz_r7", 32'(haz1), 32'd1);
        set_alu(5'd7, 32'h5);
        tick();
        idle_inputs();
        check_wb("alu_r7", 1'b1, 5'd7, 32'h5, 2'd1);
        check("haz_r7_killed", 32'(haz1), 32'd0);
        tick();
        check_wb("kill_pop", 1'b0, 5'd7, 32'h5, 2'd0);
        tick();
        check_wb("kill_idle", 1'b0, 5'd7, 32'h5, 2'd0);
        rd_reg1 = '0;

        // writes to r0 are consumed silently
        set_alu(5'd0, 32'hFF);
        tick();
        idle_inputs();
        check_wb("alu_r0", 1'b0, 5'd7, 32'h5, 2'd0);
        set_alu(5'd8, 32'h8);
        set_ld(5'd0, 32'h99);
        tick();
        idle_inputs();
        rd_reg0 = 5'd0;
        #1;
        check_wb("alu_r8", 1'b1, 5'd8, 32'h8, 2'd1);
        check("haz_r0", 32'(haz0), 32'd0);
        check("fwd_r0", 32'(fwd0_hit), 32'd0);
        tick();
        check_wb("pop_r0", 1'b0, 5'd8, 32'h8, 2'd0);

        // forwarding of the in-flight commit
        set_alu(5'd9, 32'h33);
        tick();
        idle_inputs();
        rd_reg0 = 5'd9;
        rd_reg1 = 5'd3;
        #1;
        check("fwd0.hit", 32'(fwd0_hit), 32'd1);
        check("fwd0.val", fwd0_val, 32'h33);
        check("fwd1.hit", 32'(fwd1_hit), 32'd0);
        rd_reg1 = 5'd9;
        #1;
        check("fwd1.hit9", 32'(fwd1_hit), 32'd1);
        tick();
        check("fwd0.idle", 32'(fwd0_hit), 32'd0);
        rd_reg0 = '0;
        rd_reg1 = '0;

        // reset with a load buffered
        set_alu(5'd1, 32'h10);
        set_ld(5'd2, 32'h20);
        tick();
        idle_inputs();
        check("mid.pend", 32'(pending), 32'd1);
        rst_n = 1'b0;
        #1;
        check_wb("mid_reset", 1'b0, 5'd0, 32'h0, 2'd0);
        check("mid_reset.ready", 32'(ld_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_wb("after_reset", 1'b0, 5'd0, 32'h0, 2'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
